cr_prefix_fe_char_win: RTL and testbench

//  NUM_FE parallel character feature extractors over one byte stream, each comparing a selectable

---
 rtl/cr_prefix_fe_char_win_pkg.sv | 27 ++
 rtl/cr_prefix_fe_char_win_if.sv | 31 +++
 rtl/cr_prefix_fe_char_win_cmp.sv | 46 ++++
 rtl/cr_prefix_fe_char_win.sv | 132 +++++++++++++
 tb/tb_cr_prefix_fe_char_win.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cr_prefix_fe_char_win_pkg.sv
// ---------------------------------------------------------------------------
// cr_prefix_fe_char_win_pkg
// Shared types for the character-window feature extractor.
//   FE_TAP_W      : width of the per-feature window tap select
//   fe_cmp_e      : compare operator (tap char vs match value, unsigned)
//   feature_win_t : static per-feature configuration word
// ---------------------------------------------------------------------------
package cr_prefix_fe_char_win_pkg;

    localparam int FE_TAP_W = 3;

    typedef enum logic [1:0] {
        FE_CMP_LE = 2'b00,
        FE_CMP_EQ = 2'b01,
        FE_CMP_GT = 2'b10,
        FE_CMP_GE = 2'b11
    } fe_cmp_e;

    typedef struct packed {
        logic                enable;
        logic                use_prior;
        fe_cmp_e             cmp_type;
        logic [FE_TAP_W-1:0] tap;
        logic [7:0]          match_val;
    } feature_win_t;

endpackage

// File: rtl/cr_prefix_fe_char_win_if.sv
// ---------------------------------------------------------------------------
// cr_prefix_fe_char_win_if
// Character stream in / match vector out of the feature extractor.
//   fe_prior_in    : prior for feature unit 0
//   fe_char_in     : stream character
//   fe_char_valid  : character qualifier
//   fe_char_eof    : last character of the frame (qualified by valid)
//   fe_match       : registered per-feature match vector
//   fe_match_valid : fe_match qualifier
// master = stream source / match sink, slave = extractor.
// ---------------------------------------------------------------------------
interface cr_prefix_fe_char_win_if #(
    parameter int NUM_FE = 8
);
    logic              fe_prior_in;
    logic [7:0]        fe_char_in;
    logic              fe_char_valid;
    logic              fe_char_eof;
    logic [NUM_FE-1:0] fe_match;
    logic              fe_match_valid;

    modport master (
        output fe_prior_in, fe_char_in, fe_char_valid, fe_char_eof,
        input  fe_match, fe_match_valid
    );

    modport slave (
        input  fe_prior_in, fe_char_in, fe_char_valid, fe_char_eof,
        output fe_match, fe_match_valid
    );
endinterface

// File: rtl/cr_prefix_fe_char_win_cmp.sv
// ---------------------------------------------------------------------------
// cr_prefix_fe_char_win_cmp
// Combinational tap select + compare for one feature unit.
//   i_tap_chr / i_tap_vld : window view, index 0 = current char
//   i_cfg                 : feature configuration
//   o_raw                 : enable & tap valid & compare result
// A tap at or beyond WIN_DEPTH selects nothing and never matches.
// ---------------------------------------------------------------------------
module cr_prefix_fe_char_win_cmp
    import cr_prefix_fe_char_win_pkg::*;
#(
    parameter int WIN_DEPTH = 4
) (
    input  logic [WIN_DEPTH-1:0][7:0] i_tap_chr,
    input  logic [WIN_DEPTH-1:0]      i_tap_vld,
    input  feature_win_t              i_cfg,
    output logic                      o_raw
);
    logic       w_sel_vld;
    logic [7:0] w_sel_chr;
    logic       w_cmp;

    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_chr = '0;
        for (int k = 0; k < WIN_DEPTH; k++) begin
            if (i_cfg.tap == FE_TAP_W'(k)) begin
                w_sel_vld = i_tap_vld[k];
                w_sel_chr = i_tap_chr[k];
            end
        end
    end

    always_comb begin
        case (i_cfg.cmp_type)
            FE_CMP_LE: w_cmp = (w_sel_chr <= i_cfg.match_val);
            FE_CMP_EQ: w_cmp = (w_sel_chr == i_cfg.match_val);
            FE_CMP_GT: w_cmp = (w_sel_chr >  i_cfg.match_val);
            FE_CMP_GE: w_cmp = (w_sel_chr >= i_cfg.match_val);
            default:   w_cmp = 1'b0;
        endcase
    end

    assign o_raw = i_cfg.enable & w_sel_vld & w_cmp;

endmodule

// File: rtl/cr_prefix_fe_char_win.sv
// ---------------------------------------------------------------------------
// cr_prefix_fe_char_win
// NUM_FE parallel character feature extractors over one byte stream.
// Each unit compares a selectable window tap against its match value; units
// chain through a prior so unit i can require unit i-1 to hit on the same char.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus (slave)    : char stream in, registered match vector out
//   i_fe_config    : static per-feature configuration
//   i_fe_cnt_clr   : synchronous clear of all hit counters
//   o_fe_hit_cnt   : saturating per-feature hit counters
// Optional feature: define CR_PREFIX_FE_CNT_EN to build the hit counters;
// otherwise o_fe_hit_cnt is tied to zero and i_fe_cnt_clr is ignored.
// ---------------------------------------------------------------------------
module cr_prefix_fe_char_win
    import cr_prefix_fe_char_win_pkg::*;
#(
    parameter int NUM_FE    = 8,
    parameter int WIN_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    cr_prefix_fe_char_win_if.slave         bus,
    input  feature_win_t [NUM_FE-1:0]      i_fe_config,
    input  logic                           i_fe_cnt_clr,
    output logic [NUM_FE-1:0][CNT_W-1:0]   o_fe_hit_cnt
);
    // History holds taps 1..WIN_DEPTH-1; tap 0 is the live input char.
    localparam int HIST_N = (WIN_DEPTH > 1) ? WIN_DEPTH - 1 : 1;

    logic [HIST_N-1:0][7:0]    r_hist_chr;
    logic [HIST_N-1:0]         r_hist_vld;
    logic [WIN_DEPTH-1:0][7:0] w_tap_chr;
    logic [WIN_DEPTH-1:0]      w_tap_vld;
    logic [NUM_FE-1:0]         w_raw;
    logic [NUM_FE-1:0]         w_hit;
    logic [NUM_FE-1:0]         r_match;
    logic                      r_match_valid;

    always_comb begin
        w_tap_chr    = '0;
        w_tap_vld    = '0;
        w_tap_chr[0] = bus.fe_char_in;
        w_tap_vld[0] = bus.fe_char_valid;
        for (int k = 1; k < WIN_DEPTH; k++) begin
            w_tap_chr[k] = r_hist_chr[k-1];
            w_tap_vld[k] = r_hist_vld[k-1];
        end
    end

    // EOF char is compared normally, then the frame history is invalidated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist_chr <= '0;
            r_hist_vld <= '0;
        end else if (bus.fe_char_valid) begin
            if (bus.fe_char_eof) begin
                r_hist_vld <= '0;
            end else begin
                r_hist_chr[0] <= bus.fe_char_in;
                r_hist_vld[0] <= (WIN_DEPTH > 1);
                for (int k = 1; k < HIST_N; k++) begin
                    r_hist_chr[k] <= r_hist_chr[k-1];
                    r_hist_vld[k] <= r_hist_vld[k-1];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_FE; i++) begin : g_fe
        cr_prefix_fe_char_win_cmp #(
            .WIN_DEPTH (WIN_DEPTH)
        ) u_cmp (
            .i_tap_chr (w_tap_chr),
            .i_tap_vld (w_tap_vld),
            .i_cfg     (i_fe_config[i]),
            .o_raw     (w_raw[i])
        );
    end

    // Ripple prior chain: each unit's prior is the previous unit's final hit.
    always_comb begin
        logic v_prior;
        v_prior = bus.fe_prior_in;
        w_hit   = '0;
        for (int i = 0; i < NUM_FE; i++) begin
            w_hit[i] = w_raw[i] & ~(i_fe_config[i].use_prior & ~v_prior);
            v_prior  = w_hit[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match       <= '0;
            r_match_valid <= 1'b0;
        end else if (bus.fe_char_valid) begin
            r_match       <= w_hit;
            r_match_valid <= 1'b1;
        end else begin
            r_match       <= '0;
            r_match_valid <= 1'b0;
        end
    end

    assign bus.fe_match       = r_match;
    assign bus.fe_match_valid = r_match_valid;

`ifdef CR_PREFIX_FE_CNT_EN
    logic [NUM_FE-1:0][CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_FE; i++) begin
                if (i_fe_cnt_clr) begin
                    r_cnt[i] <= '0;
                end else if (r_match_valid && r_match[i] && !(&r_cnt[i])) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign o_fe_hit_cnt = r_cnt;
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = i_fe_cnt_clr;
    assign o_fe_hit_cnt     = '0;
`endif

endmodule

// File: tb/tb_cr_prefix_fe_char_win.sv
module tb_cr_prefix_fe_char_win;
    import cr_prefix_fe_char_win_pkg::*;

    localparam int NUM_FE    = 8;
    localparam int WIN_DEPTH = 4;
    localparam int CNT_W     = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    feature_win_t [NUM_FE-1:0]    cfg;
    logic                         cnt_clr;
    logic [NUM_FE-1:0][CNT_W-1:0] hit_cnt;

    int checks = 0;
    int errors = 0;

    cr_prefix_fe_char_win_if #(.NUM_FE(NUM_FE)) bus ();

    cr_prefix_fe_char_win #(
        .NUM_FE    (NUM_FE),
        .WIN_DEPTH (WIN_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .i_fe_config  (cfg),
        .i_fe_cnt_clr (cnt_clr),
        .o_fe_hit_cnt (hit_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    int                m_hist[WIN_DEPTH];   // m_hist[0] = previous char in frame
    int                m_flen;              // chars of this frame available as history
    logic [NUM_FE-1:0] exp_match;
    logic              exp_valid;
    int                exp_cnt[NUM_FE];

    function automatic logic [NUM_FE-1:0] model_hits(input int c, input logic prior);
        logic [NUM_FE-1:0] h;
        logic p, tv, cmp;
        int t, tc, m;
        h = '0;
        p = prior;
        for (int i = 0; i < NUM_FE; i++) begin
            t = int'(cfg[i].tap);
            m = int'(cfg[i].match_val);
            if (t == 0) begin
                tv = 1'b1; tc = c;
            end else if (t < WIN_DEPTH && t <= m_flen) begin
                tv = 1'b1; tc = m_hist[t-1];
            end else begin
                tv = 1'b0; tc = 0;
            end
            case (cfg[i].cmp_type)
                FE_CMP_LE: cmp = (tc <= m);
                FE_CMP_EQ: cmp = (tc == m);
                FE_CMP_GT: cmp = (tc >  m);
                default:   cmp = (tc >= m);
            endcase
            h[i] = cfg[i].enable && tv && cmp && (!cfg[i].use_prior || p);
            p = h[i];
        end
        return h;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flen    = 0;
            exp_match = '0;
            exp_valid = 1'b0;
            for (int i = 0; i < NUM_FE; i++) exp_cnt[i] = 0;
        end else begin
`ifdef CR_PREFIX_FE_CNT_EN
            for (int i = 0; i < NUM_FE; i++) begin
                if (cnt_clr) exp_cnt[i] = 0;
                else if (exp_valid && exp_match[i] && exp_cnt[i] < (1 << CNT_W) - 1)
                    exp_cnt[i] = exp_cnt[i] + 1;
            end
`endif
            if (bus.fe_char_valid) begin
                exp_match = model_hits(int'(bus.fe_char_in), bus.fe_prior_in);
                exp_valid = 1'b1;
                if (bus.fe_char_eof) begin
                    m_flen = 0;
                end else begin
                    for (int k = WIN_DEPTH - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
                    m_hist[0] = int'(bus.fe_char_in);
                    if (m_flen < WIN_DEPTH - 1) m_flen = m_flen + 1;
                end
            end else begin
                exp_match = '0;
                exp_valid = 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_match", 64'(bus.fe_match), 64'(exp_match));
        chk("cmp_match_valid", 64'(bus.fe_match_valid), 64'(exp_valid));
        for (int i = 0; i < NUM_FE; i++)
            chk($sformatf("cmp_cnt%0d", i), 64'(hit_cnt[i]), 64'(exp_cnt[i]));
    end

    // ---------------- stimulus helpers ----------------
    function automatic feature_win_t mk(input logic en, input logic up, input fe_cmp_e ct,
                                        input int tap, input int m);
        feature_win_t f;
        f.enable    = en;
        f.use_prior = up;
        f.cmp_type  = ct;
        f.tap       = FE_TAP_W'(tap);
        f.match_val = 8'(m);
        return f;
    endfunction

    task automatic cfg_off();
        for (int i = 0; i < NUM_FE; i++) cfg[i] = mk(1'b0, 1'b0, FE_CMP_EQ, 0, 0);
    endtask

    // Drive one valid char, then check one unit's match bit right after the edge.
    task automatic send_chk(input string name, input int c, input logic eof, input logic prior,
                            input int unit, input logic exp_bit);
        @(negedge clk);
        bus.fe_char_in    = 8'(c);
        bus.fe_char_valid = 1'b1;
        bus.fe_char_eof   = eof;
        bus.fe_prior_in   = prior;
        @(posedge clk);
        #1;
        chk(name, 64'(bus.fe_match[unit]), 64'(exp_bit));
        chk({name, "_vld"}, 64'(bus.fe_match_valid), 64'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.fe_char_valid = 1'b0;
            bus.fe_char_eof   = 1'b0;
        end
    endtask

    initial begin
        bus.fe_char_in    = '0;
        bus.fe_char_valid = 1'b0;
        bus.fe_char_eof   = 1'b0;
        bus.fe_prior_in   = 1'b0;
        cnt_clr           = 1'b0;
        cfg_off();
        #2;
        chk("rst_match", 64'(bus.fe_match), 64'd0);
        chk("rst_valid", 64'(bus.fe_match_valid), 64'd0);
        chk("rst_cnt", 64'(hit_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: unit0 EQ tap0 0x41
        cfg[0] = mk(1'b1, 1'b0, FE_CMP_EQ, 0, 8'h41);
        send_chk("t1_40", 8'h40, 1'b0, 1'b0, 0, 1'b0);
        send_chk("t1_41", 8'h41, 1'b0, 1'b0, 0, 1'b1);
        send_chk("t1_42", 8'h42, 1'b1, 1'b0, 0, 1'b0);

        // 2: unit1 EQ tap2 'a' over frame "abc"
        cfg_off();
        cfg[1] = mk(1'b1, 1'b0, FE_CMP_EQ, 2, "a");
        send_chk("t2_a", "a", 1'b0, 1'b0, 1, 1'b0);
        send_chk("t2_b", "b", 1'b0, 1'b0, 1, 1'b0);
        send_chk("t2_c", "c", 1'b1, 1'b0, 1, 1'b1);

        // 3: digit range via prior chaining
        cfg_off();
        cfg[0] = mk(1'b1, 1'b0, FE_CMP_GE, 0, "0");
        cfg[1] = mk(1'b1, 1'b1, FE_CMP_LE, 0, "9");
        send_chk("t3_5_u0", "5", 1'b0, 1'b0, 0, 1'b1);
        chk("t3_5_u1", 64'(bus.fe_match[1]), 64'd1);
        send_chk("t3_A_u0", "A", 1'b1, 1'b0, 0, 1'b1);
        chk("t3_A_u1", 64'(bus.fe_match[1]), 64'd0);
        cfg[0].use_prior = 1'b1;
        send_chk("t3_p0_u0", "5", 1'b1, 1'b0, 0, 1'b0);
        chk("t3_p0_u1", 64'(bus.fe_match[1]), 64'd0);
        send_chk("t3_p1_u1", "5", 1'b1, 1'b1, 1, 1'b1);

        // 4: EOF clears history
        cfg_off();
        cfg[2] = mk(1'b1, 1'b0, FE_CMP_EQ, 1, "x");
        cfg[3] = mk(1'b1, 1'b0, FE_CMP_EQ, 0, "x");
        send_chk("t4_x_u3", "x", 1'b1, 1'b0, 3, 1'b1);
        send_chk("t4_y_u2", "y", 1'b0, 1'b0, 2, 1'b0);
        send_chk("t4_z_u2", "z", 1'b1, 1'b0, 2, 1'b0);
        send_chk("t4_x2", "x", 1'b0, 1'b0, 2, 1'b0);
        send_chk("t4_y2_u2", "y", 1'b1, 1'b0, 2, 1'b1);

        // 6: async reset mid-frame with a full window
        cfg_off();
        cfg[4] = mk(1'b1, 1'b0, FE_CMP_EQ, 1, "d");
        cfg[5] = mk(1'b1, 1'b0, FE_CMP_EQ, 0, "d");
        send_chk("t6_a", "a", 1'b0, 1'b0, 5, 1'b0);
        send_chk("t6_b", "b", 1'b0, 1'b0, 5, 1'b0);
        send_chk("t6_c", "c", 1'b0, 1'b0, 5, 1'b0);
        send_chk("t6_d", "d", 1'b0, 1'b0, 5, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_match", 64'(bus.fe_match), 64'd0);
        chk("t6_rst_valid", 64'(bus.fe_match_valid), 64'd0);
        idle(1);
        rst_n = 1'b1;
        send_chk("t6_e_u4", "e", 1'b0, 1'b0, 4, 1'b0);

        // 5: saturating counter and clear priority
        cfg_off();
        cfg[6] = mk(1'b1, 1'b0, FE_CMP_EQ, 0, "h");
        for (int k = 0; k < 5; k++) send_chk("t5_h", "h", 1'b0, 1'b0, 6, 1'b1);
        idle(2);
        @(posedge clk); #1;
`ifdef CR_PREFIX_FE_CNT_EN
        chk("t5_sat", 64'(hit_cnt[6]), 64'd3);
`else
        chk("t5_sat", 64'(hit_cnt[6]), 64'd0);
`endif
        send_chk("t5_hclr", "h", 1'b1, 1'b0, 6, 1'b1);
        @(negedge clk);
        bus.fe_char_valid = 1'b0;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        chk("t5_clr", 64'(hit_cnt[6]), 64'd0);
        @(negedge clk);
        cnt_clr = 1'b0;

        // random phase
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (n % 200 == 0) begin
                for (int i = 0; i < NUM_FE; i++)
                    cfg[i] = mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                                fe_cmp_e'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                                int'($urandom_range(8'h40, 8'h47)));
            end
            bus.fe_char_valid = ($urandom_range(0, 3) != 0);
            bus.fe_char_eof   = ($urandom_range(0, 6) == 0);
            bus.fe_prior_in   = 1'($urandom_range(0, 1));
            bus.fe_char_in    = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                            : 8'($urandom_range(8'h40, 8'h47));
            cnt_clr           = ($urandom_range(0, 19) == 0);
        end
        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
